step_sequencer: RTL

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/step_sequencer.sv
// Eight-step pattern sequencer: an editable 8-bit step-enable pattern, a step counter paced by
// TICKS_PER_STEP clock cycles, and strobe/gate/trigger outputs for the note voice.
module step_sequencer #(
  parameter int unsigned TICKS_PER_STEP = 3000000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] toggle,
  input  logic       sequencer_on,
  input  logic       play,
  output logic [7:0] pattern,
  output logic [2:0] step,
  output logic       step_strobe,
  output logic       note_gate,
  output logic       note_trig
);

  localparam logic [CNT_W-1:0] LastTick = CNT_W'(TICKS_PER_STEP - 1);

  typedef enum logic [1:0] {StOff, StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       step_q, step_d;
  logic             strobe_q, strobe_d;
  logic [7:0]       pattern_q, pattern_d;
  logic             staying_run, wrap, advance, run_entry;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StOff;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows the control levels; sequencer_on dominates play.
  always_comb begin
    state_d = StOff;
    if (sequencer_on) begin
      state_d = play ? StRun : StIdle;
    end
  end

  // Datapath next-state
  always_comb begin
    staying_run = (state_q == StRun) && (state_d == StRun);
    run_entry   = (state_q != StRun) && (state_d == StRun);
    wrap        = (cnt_q == LastTick);
    advance     = staying_run && wrap;

    // Counter only runs while RUN persists; entry, pause and off all restart it from zero.
    cnt_d = '0;
    if (staying_run && !wrap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    step_d = step_q;
    if (state_d == StOff) begin
      step_d = '0;
    end else if (advance) begin
      step_d = step_q + 3'd1;
    end

    strobe_d  = advance || run_entry;
    pattern_d = sequencer_on ? (pattern_q ^ toggle) : pattern_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q     <= '0;
      step_q    <= '0;
      strobe_q  <= 1'b0;
      pattern_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      strobe_q  <= strobe_d;
      pattern_q <= pattern_d;
    end
  end

  // Outputs
  always_comb begin
    pattern     = pattern_q;
    step        = step_q;
    step_strobe = strobe_q;
    note_gate   = (state_q == StRun) && pattern_q[step_q];
    note_trig   = strobe_q && pattern_q[step_q];
  end

endmodule
